y86_fetch_unit: RTL
===================

// Module: y86_fetch_unit
// PURPOSE
// - Y86-64 SEQ fetch stage; sits directly downstream of PC update.
// - Accepts the next PC and reads the instruction byte-serially over a byte-wide imem req/ack port.
// - Splits the instruction into icode/ifun/rA/rB/valC, computes valP and a Y86 status code.
// - Results feed decode/execute; valP/valC return to PC update.
// PARAMETERS
// - IMEM_BYTES  1024  instruction memory size in bytes; any addr >= IMEM_BYTES is out of range
// PORTS
// - clk         in   1   single clock, rising edge
// - rst_n       in   1   asynchronous, active-low reset
// - start       in   1   begin fetch at pc_in; sampled only in IDLE
// - pc_in       in   64  PC from PC update stage
// - imem_req    out  1   byte read request; held until imem_ack or imem_err
// - imem_addr   out  64  byte address = pc + byte_idx (mod 2^64)
// - imem_rdata  in   8   read byte; valid when imem_ack=1
// - imem_ack    in   1   byte accepted at this edge (same-cycle ack allowed)
// - imem_err    in   1   memory fault; has priority over imem_ack
// - busy        out  1   high in REQ and DONE
// - done        out  1   one-cycle pulse; all result outputs valid from that cycle
// - icode,ifun  out  4,4 instruction byte 0, upper/lower nibble
// - rA,rB       out  4,4 register byte, upper/lower nibble; 4'hF if no register byte
// - valC        out  64  little-endian constant; 0 if none
// - valP        out  64  pc + instruction length (mod 2^64)
// - stat        out  3   1=AOK 2=HLT 3=ADR 4=INS
// BEHAVIOUR
// - Reset: state IDLE, byte_idx 0; all outputs 0 except rA=rB=4'hF, stat=1.
// - Reset mid-fetch: imem_req drops immediately (async); partial results discarded.
// - FSM: IDLE -start-> REQ; REQ -last byte ack | error-> DONE; DONE -> IDLE unconditionally.
// - start while not IDLE: ignored, not queued.
// - On start: latch pc_in; clear rA/rB to F, valC to 0, stat to 1.
// - REQ state:
//   - byte_idx counts 0..9; imem_req=1 only when imem_addr < IMEM_BYTES.
//   - One byte accepted per edge with imem_ack=1.
// - Length by icode, fixed after byte 0:
//   - 0,1,9 -> 1
//   - 2,6,A,B -> 2
//   - 7,8 -> 9; valC = bytes 1..8
//   - 3,4,5 -> 10; register byte 1, valC = bytes 2..9
// - Register byte: rA=[7:4], rB=[3:0].
// - icode 0: stat=HLT after byte 0; icode > B: stat=INS after byte 0; no further requests.
// - Address out of range: no request; stat=ADR; next state DONE.
// - imem_err: stat=ADR; next state DONE.
// - Any error or HLT/INS: valP = latched pc; fetched fields keep captured values.
// - Latency with zero-wait ack: start at edge 0; byte k accepted at edge k+1; done high during cycle after edge N.
// - Result outputs hold from done until the next accepted start.
// CONFIGURATION
// - IFUN_CHECK_EN defined:
//   - stat=INS after byte 0 for invalid ifun: icode 2/7 with ifun > 6, icode 6 with ifun > 3, any other icode with ifun != 0.
// - IFUN_CHECK_EN undefined:
//   - ifun captured but never checked; validity depends on icode only.
// TESTING
// - pc_in=0, mem 30 F3 0A 00.. (irmovq $10,%rbx), ack every cycle:
//   - done 11 cycles after start; rA=F, rB=3, valC=10, valP=10, stat=1.
// - pc_in=0x20, mem 70 40 00.. (jmp 0x40), ack after 2 waits/byte:
//   - done after 9 bytes; icode=7, valC=0x40, valP=0x29.
// - pc_in=0x5, mem byte 00 (halt):
//   - one request only; stat=2, valP=5.
// - pc_in=IMEM_BYTES-2, irmovq opcode:
//   - 2 bytes read; no req at addr IMEM_BYTES; stat=3.
// - pc_in=0, byte 0 = C0:
//   - stat=4 after one byte.
// - Other cases:
//   - imem_err on byte 3 -> stat=3.
//   - rst_n low mid-REQ -> imem_req=0 same cycle.
//   - 2 with IFUN_CHECK_EN -> stat=4.

Source files
------------

// File: rtl/y86_fetch_unit.sv
// Y86-64 SEQ fetch stage: reads one instruction byte-serially over a req/ack port and decodes it.
// Optional feature: define IFUN_CHECK_EN to flag invalid ifun values as INS.
module y86_fetch_unit #(
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pc_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_ack,
  input  logic        imem_err,
  output logic        busy,
  output logic        done,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat
);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [3:0]  byte_idx_q;
  logic [3:0]  len_q;

  logic [3:0]  b0_icode, b0_ifun, b0_len;
  logic        in_range, ifun_bad, b0_invalid, has_reg, jump_fmt, last_byte;
  logic [2:0]  cidx;

  function automatic logic [3:0] inst_len(input logic [3:0] ic);
    logic [3:0] len;
    unique case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                len = 4'd1;
    endcase
    return len;
  endfunction

  assign imem_addr = pc_q + {60'd0, byte_idx_q};
  assign in_range  = imem_addr < 64'(IMEM_BYTES);
  assign imem_req  = (state_q == StReq) && in_range;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  assign b0_icode   = imem_rdata[7:4];
  assign b0_ifun    = imem_rdata[3:0];
  assign b0_len     = inst_len(b0_icode);
  assign b0_invalid = (b0_icode > 4'hB) || ifun_bad;

  always_comb begin
    ifun_bad = 1'b0;
`ifdef IFUN_CHECK_EN
    unique case (b0_icode)
      4'h2, 4'h7: ifun_bad = (b0_ifun > 4'h6);
      4'h6:       ifun_bad = (b0_ifun > 4'h3);
      default:    ifun_bad = (b0_ifun != 4'h0);
    endcase
`endif
  end

  // Register byte follows byte 0 for every format except jXX/call (7/8) and the 1-byte ones.
  assign has_reg   = (icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
  assign jump_fmt  = (icode == 4'h7) || (icode == 4'h8);
  assign cidx      = byte_idx_q[2:0] - (jump_fmt ? 3'd1 : 3'd2);
  assign last_byte = (byte_idx_q == len_q - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      byte_idx_q <= '0;
      len_q      <= '0;
      icode      <= '0;
      ifun       <= '0;
      rA         <= 4'hF;
      rB         <= 4'hF;
      valC       <= '0;
      valP       <= '0;
      stat       <= StatAok;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StReq;
            pc_q       <= pc_in;
            byte_idx_q <= '0;
            rA         <= 4'hF;
            rB         <= 4'hF;
            valC       <= '0;
            stat       <= StatAok;
          end
        end
        StReq: begin
          if (!in_range || imem_err) begin
            stat    <= StatAdr;
            valP    <= pc_q;
            state_q <= StDone;
          end else if (imem_ack) begin
            if (byte_idx_q == 4'd0) begin
              icode <= b0_icode;
              ifun  <= b0_ifun;
              if (b0_invalid) begin
                stat    <= StatIns;
                valP    <= pc_q;
                state_q <= StDone;
              end else if (b0_icode == 4'h0) begin
                stat    <= StatHlt;
                valP    <= pc_q;
                state_q <= StDone;
              end else if (b0_len == 4'd1) begin
                valP    <= pc_q + 64'd1;
                state_q <= StDone;
              end else begin
                len_q      <= b0_len;
                byte_idx_q <= 4'd1;
              end
            end else begin
              if (has_reg && byte_idx_q == 4'd1) begin
                rA <= imem_rdata[7:4];
                rB <= imem_rdata[3:0];
              end else begin
                valC[{cidx, 3'b000} +: 8] <= imem_rdata;
              end
              if (last_byte) begin
                valP    <= pc_q + {60'd0, len_q};
                state_q <= StDone;
              end else begin
                byte_idx_q <= byte_idx_q + 4'd1;
              end
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
